fb_scanout_reader: RTL and testbench

- Reads the finished framebuffer out of SDRAM, one 640-pixel line at a time, for VGA scanout.
- It is the read-side counterpart of the sprite drawer: the drawer writes 128-bit, 16-pixel words into the back buffer, and this block fetches the front buffer.
- Fetched words go into a two-bank line buffer. The VGA side reads one 8-bit palette index per pixel.

---
 rtl/fb_pkg.sv | 10 +
 rtl/scan_line_buf.sv | 24 ++
 rtl/fb_scanout_reader.sv | 127 ++++++++++++
 tb/tb_fb_scanout_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer layout shared with the sprite drawer, plus scanout FSM states.
package fb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DRAIN} fb_state_t;
   localparam logic [21:0] FB_BASE0 = 22'h100000;
   localparam logic [21:0] FB_BASE1 = 22'h200000;
   localparam int WORDS_PER_LINE = 40;
   function automatic logic [21:0] line_offset(input logic [9:0] line);
      return ({12'd0, line} << 5) + ({12'd0, line} << 3);
   endfunction
endpackage

// File: rtl/scan_line_buf.sv
// scan_line_buf: two banks of one scanline (40 x 128-bit words), one write port, one registered read port.
module scan_line_buf
   import fb_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_bank,
   input  logic [5:0]   wr_idx,
   input  logic [127:0] wr_data,
   input  logic         we,
   input  logic         rd_bank,
   input  logic [5:0]   rd_idx,
   output logic [127:0] rd_data
);
   logic [127:0] mem_q [2][WORDS_PER_LINE];
   logic [127:0] rd_data_q, rd_data_d;
   always_comb rd_data_d = mem_q[rd_bank][rd_idx];
   always_ff @(posedge clk)
      if (we) mem_q[wr_bank][wr_idx] <= wr_data;
   always_ff @(posedge clk or negedge reset)
      if (!reset) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   assign rd_data = rd_data_q;
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: prefetches one framebuffer line per line_req from SDRAM into a
// double-banked line buffer and serves 8-bit palette indices to the VGA side.
module fb_scanout_reader
   import fb_pkg::*;
#(
   parameter int VISIBLE_LINES = 480
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         new_frame,
   input  logic         frame_flip,
   input  logic         line_req,
   input  logic [9:0]   line_num,
   input  logic         sdram_wait,
   input  logic         sdram_ac,
   input  logic         sdram_rd_valid,
   input  logic [127:0] sdram_rd_data,
   output logic         sdram_rd,
   output logic [21:0]  sdram_addr,
   input  logic [9:0]   pix_x,
   output logic [7:0]   pix_out,
   output logic         busy,
   output logic         underrun
);
   localparam logic [9:0] VIS = 10'(VISIBLE_LINES);
   localparam logic [5:0] LAST = 6'(WORDS_PER_LINE - 1);
   fb_state_t state_q, state_d;
   logic disp_bank_q, disp_bank_d, fill_bank_q, fill_bank_d, disp_sel_q, disp_sel_d;
   logic [5:0] word_cnt_q, word_cnt_d;
   logic [9:0] line_q, line_d;
   logic sdram_rd_q, sdram_rd_d, busy_q, busy_d, underrun_q, underrun_d;
   logic [21:0] sdram_addr_q, sdram_addr_d, fetch_addr;
   logic [3:0] pix_sel_q, pix_sel_d;
   logic pix_oob_q, pix_oob_d, new_ok, we;
   logic [127:0] rd_word;
   always_comb begin
      fetch_addr = (disp_sel_q ? FB_BASE1 : FB_BASE0) + line_offset(line_q) + {16'd0, word_cnt_q};
      new_ok = line_num < VIS;
      we = state_q == WAIT_DATA && sdram_rd_valid && !line_req;
      state_d = state_q;
      word_cnt_d = word_cnt_q;
      sdram_rd_d = sdram_rd_q;
      sdram_addr_d = sdram_addr_q;
      disp_sel_d = new_frame ? ~frame_flip : disp_sel_q;
      disp_bank_d = line_req ? fill_bank_q : disp_bank_q;
      fill_bank_d = line_req ? disp_bank_q : fill_bank_q;
      line_d = line_req ? line_num : line_q;
      underrun_d = line_req && state_q != IDLE;
      case (state_q)
         IDLE: if (line_req && new_ok) begin
            state_d = ISSUE;
            word_cnt_d = '0;
         end
         ISSUE: if (line_req) begin
            sdram_rd_d = 1'b0;
            word_cnt_d = '0;
            state_d = (sdram_rd_q && sdram_ac) ? DRAIN : new_ok ? ISSUE : IDLE;
         end else if (sdram_rd_q && sdram_ac) begin
            sdram_rd_d = 1'b0;
            state_d = WAIT_DATA;
         end else if (!sdram_rd_q && !sdram_wait) begin
            sdram_rd_d = 1'b1;
            sdram_addr_d = fetch_addr;
         end
         // Data landing with the interrupting line_req settles the outstanding read, so skip DRAIN.
         WAIT_DATA: if (line_req) begin
            word_cnt_d = '0;
            state_d = !sdram_rd_valid ? DRAIN : new_ok ? ISSUE : IDLE;
         end else if (sdram_rd_valid) begin
            word_cnt_d = word_cnt_q + 6'd1;
            state_d = word_cnt_q == LAST ? IDLE : ISSUE;
         end
         DRAIN: begin
            word_cnt_d = '0;
            state_d = !sdram_rd_valid ? DRAIN : (line_req ? new_ok : line_q < VIS) ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      pix_sel_d = pix_x[3:0];
      pix_oob_d = pix_x >= 10'd640;
      pix_out = pix_oob_q ? 8'h00 : rd_word[{pix_sel_q, 3'b000} +: 8];
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         disp_bank_q <= 1'b0;
         fill_bank_q <= 1'b1;
         disp_sel_q <= 1'b0;
         word_cnt_q <= '0;
         line_q <= '0;
         sdram_rd_q <= 1'b0;
         sdram_addr_q <= '0;
         busy_q <= 1'b0;
         underrun_q <= 1'b0;
         pix_sel_q <= '0;
         pix_oob_q <= 1'b0;
      end else begin
         state_q <= state_d;
         disp_bank_q <= disp_bank_d;
         fill_bank_q <= fill_bank_d;
         disp_sel_q <= disp_sel_d;
         word_cnt_q <= word_cnt_d;
         line_q <= line_d;
         sdram_rd_q <= sdram_rd_d;
         sdram_addr_q <= sdram_addr_d;
         busy_q <= busy_d;
         underrun_q <= underrun_d;
         pix_sel_q <= pix_sel_d;
         pix_oob_q <= pix_oob_d;
      end
   scan_line_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_bank (fill_bank_q),
      .wr_idx  (word_cnt_q),
      .wr_data (sdram_rd_data),
      .we      (we),
      .rd_bank (disp_bank_q),
      .rd_idx  (pix_x[9:4]),
      .rd_data (rd_word)
   );
   assign sdram_rd = sdram_rd_q;
   assign sdram_addr = sdram_addr_q;
   assign busy = busy_q;
   assign underrun = underrun_q;
endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader: table-driven line fetches against an SDRAM model with an address scoreboard.
module tb_fb_scanout_reader;
   logic clk = 1'b0, reset = 1'b0, new_frame = 1'b0, frame_flip = 1'b0, line_req = 1'b0;
   logic [9:0] line_num = '0, pix_x = '0;
   logic sdram_wait = 1'b0, sdram_ac = 1'b0, sdram_rd_valid = 1'b0;
   logic [127:0] sdram_rd_data = '0;
   logic sdram_rd, busy, underrun;
   logic [21:0] sdram_addr;
   logic [7:0] pix_out;
   int checks = 0, errors = 0;
   int acc_cnt = 0, val_cnt = 0, pend = 0;
   logic [21:0] pend_addr = '0, acc_addr = '0, first_addr = '0;
   logic first_seen = 1'b0;
   logic [21:0] exp_q[$];

   fb_scanout_reader dut (
      .clk(clk), .reset(reset), .new_frame(new_frame), .frame_flip(frame_flip),
      .line_req(line_req), .line_num(line_num), .sdram_wait(sdram_wait), .sdram_ac(sdram_ac),
      .sdram_rd_valid(sdram_rd_valid), .sdram_rd_data(sdram_rd_data), .sdram_rd(sdram_rd),
      .sdram_addr(sdram_addr), .pix_x(pix_x), .pix_out(pix_out), .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pbyte(input logic [21:0] a, input int k);
      return 8'(int'(a[7:0]) + k * 17 + 60);
   endfunction

   function automatic logic [127:0] dword(input logic [21:0] a);
      logic [127:0] d;
      for (int k = 0; k < 16; k++) d[8*k +: 8] = pbyte(a, k);
      return d;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_line(input logic [21:0] base, input int line);
      for (int w = 0; w < 40; w++) exp_q.push_back(22'(int'(base) + line * 40 + w));
   endtask

   task automatic pulse_line(input logic [9:0] ln);
      line_num = ln;
      line_req = 1'b1;
      tick();
      line_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      chk("busy_fall", busy, 0);
   endtask

   task automatic wait_acc(input int target);
      int n = 0;
      while (acc_cnt < target && n < 500) begin
         tick();
         n++;
      end
      chk("acc_reached", acc_cnt, target);
   endtask

   task automatic pix_chk(input string name, input logic [9:0] x, input logic [7:0] exp);
      pix_x = x;
      tick();
      chk(name, pix_out, exp);
   endtask

   // SDRAM model: accept one cycle after a request appears, return data two cycles after acceptance.
   always @(negedge clk) begin
      sdram_rd_valid = 1'b0;
      if (pend != 0) begin
         pend--;
         if (pend == 0) begin
            sdram_rd_valid = 1'b1;
            sdram_rd_data = dword(pend_addr);
            val_cnt++;
         end
      end
      if (sdram_ac) begin
         acc_cnt++;
         pend = 2;
         pend_addr = acc_addr;
         if (!first_seen) begin
            first_seen = 1'b1;
            first_addr = acc_addr;
         end
         if (exp_q.size() == 0) chk("unexpected_req", acc_addr, 22'h3FFFFF);
         else chk("req_addr", acc_addr, exp_q.pop_front());
      end
      sdram_ac = sdram_rd;
      acc_addr = sdram_addr;
   end

   typedef struct {
      logic        flip;
      logic [9:0]  line;
      logic        fetch;
      logic [21:0] first;
      logic        pchk;
      logic [9:0]  px;
      logic [7:0]  pexp;
   } vec_t;

   vec_t vt[5];

   initial begin
      int v0, a0, n;
      logic [21:0] base;
      vt[0] = '{1'b0, 10'd0,   1'b1, 22'h200000, 1'b0, 10'd0,   8'h00};
      vt[1] = '{1'b0, 10'd1,   1'b1, 22'h200028, 1'b1, 10'd17,  pbyte(22'h200001, 1)};
      vt[2] = '{1'b1, 10'd479, 1'b1, 22'h104AD8, 1'b1, 10'd639, pbyte(22'h20004F, 15)};
      vt[3] = '{1'b1, 10'd480, 1'b0, 22'h000000, 1'b1, 10'd16,  pbyte(22'h104AD9, 0)};
      vt[4] = '{1'b0, 10'd2,   1'b1, 22'h200050, 1'b1, 10'd640, 8'h00};

      repeat (3) tick();
      chk("rst_sdram_rd", sdram_rd, 0);
      chk("rst_sdram_addr", sdram_addr, 0);
      chk("rst_pix_out", pix_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", underrun, 0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         frame_flip = vt[i].flip;
         new_frame = 1'b1;
         tick();
         new_frame = 1'b0;
         base = vt[i].flip ? 22'h100000 : 22'h200000;
         exp_q.delete();
         if (vt[i].fetch) push_line(base, int'(vt[i].line));
         first_seen = 1'b0;
         v0 = val_cnt;
         a0 = acc_cnt;
         pulse_line(vt[i].line);
         if (vt[i].fetch) begin
            wait_idle();
            chk("first_addr", first_addr, vt[i].first);
            chk("valid_count", val_cnt - v0, 40);
            chk("sb_empty", exp_q.size(), 0);
         end else begin
            n = 0;
            for (int c = 0; c < 10; c++) begin
               if (sdram_rd || busy) n++;
               tick();
            end
            chk("no_fetch_activity", n, 0);
            chk("no_fetch_accepts", acc_cnt - a0, 0);
         end
         if (vt[i].pchk) pix_chk("pix_table", vt[i].px, vt[i].pexp);
      end
      pix_chk("pix_1023", 10'd1023, 8'h00);

      // sdram_wait gates the first request of line 3
      exp_q.delete();
      push_line(22'h200000, 3);
      sdram_wait = 1'b1;
      pulse_line(10'd3);
      n = 0;
      for (int c = 0; c < 10; c++) begin
         if (sdram_rd) n++;
         tick();
      end
      chk("wait_gate", n, 0);
      chk("wait_busy", busy, 1);
      sdram_wait = 1'b0;
      tick();
      chk("issue_after_wait", sdram_rd, 1);
      chk("issue_addr", sdram_addr, 22'h200078);
      wait_idle();
      chk("wait_sb_empty", exp_q.size(), 0);

      // line_req while word 12 of line 10 is outstanding
      exp_q.delete();
      push_line(22'h200000, 10);
      a0 = acc_cnt;
      pulse_line(10'd10);
      wait_acc(a0 + 13);
      exp_q.delete();
      push_line(22'h200000, 20);
      pulse_line(10'd20);
      chk("underrun_pulse", underrun, 1);
      chk("underrun_busy", busy, 1);
      tick();
      chk("underrun_one_cycle", underrun, 0);
      wait_idle();
      chk("restart_sb_empty", exp_q.size(), 0);
      pix_chk("partial_word11", 10'd179, pbyte(22'h20019B, 3));
      pix_chk("dropped_word12", 10'd192, pbyte(22'h20005C, 0));

      // asynchronous reset in WAIT_DATA
      exp_q.delete();
      push_line(22'h200000, 30);
      a0 = acc_cnt;
      pulse_line(10'd30);
      wait_acc(a0 + 5);
      reset = 1'b0;
      #1;
      chk("arst_sdram_rd", sdram_rd, 0);
      chk("arst_sdram_addr", sdram_addr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_underrun", underrun, 0);
      chk("arst_pix_out", pix_out, 0);
      exp_q.delete();
      repeat (4) tick();
      reset = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);
      chk("post_rst_rd", sdram_rd, 0);
      push_line(22'h100000, 7);
      first_seen = 1'b0;
      v0 = val_cnt;
      pulse_line(10'd7);
      wait_idle();
      chk("post_rst_first", first_addr, 22'h100118);
      chk("post_rst_valids", val_cnt - v0, 40);
      chk("post_rst_sb_empty", exp_q.size(), 0);
      pulse_line(10'd480);
      pix_chk("post_rst_pix", 10'd0, pbyte(22'h100118, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
